// File: rtl/input_frame_loader_if.sv
// Sample stream feeding the frame loader: valid/ready handshake with an
// end-of-frame marker. The master drives samples, the slave returns ready.
interface input_frame_loader_if #(
    parameter int IN_WIDTH = 24
) ();
    logic signed [IN_WIDTH-1:0] s_data;
    logic                       s_valid;
    logic                       s_last;
    logic                       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/input_frame_loader.sv
// Serial-to-parallel front end for the dense latency layer.
// Collects INPUT_SIZE samples into a fill buffer, commits a complete frame onto
// input_data in one cycle, drops short/long frames, and delays a valid token by
// LATENCY cycles so result_valid lines up with the dense layer's output_data.
// Optional feature: define LOADER_SAT_EN to clamp out-of-range samples to the
// WIDTH range; when undefined the low WIDTH bits are kept (wrapping).
module input_frame_loader #(
    parameter int WIDTH      = 17,
    parameter int IN_WIDTH   = 24,
    parameter int INPUT_SIZE = 32,
    parameter int LATENCY    = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input_frame_loader_if.slave                stream,
    output logic [0:INPUT_SIZE-1][WIDTH-1:0]   input_data,
    output logic                               frame_strobe,
    output logic                               result_valid,
    output logic                               frame_error,
    output logic [15:0]                        good_count,
    output logic [7:0]                         err_count
);

    localparam int IDX_W = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INPUT_SIZE - 1);

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    typedef logic [0:INPUT_SIZE-1][WIDTH-1:0] frame_t;

`ifdef LOADER_SAT_EN
    localparam logic signed [IN_WIDTH-1:0] SAT_HI = IN_WIDTH'((longint'(1) << (WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_LO = ~SAT_HI;
`endif

    // Reduce an incoming sample to the dense-layer width (same binary point).
    function automatic logic signed [WIDTH-1:0] convert_sample(input logic signed [IN_WIDTH-1:0] x);
`ifdef LOADER_SAT_EN
        if (x > SAT_HI) return WIDTH'(SAT_HI);
        if (x < SAT_LO) return WIDTH'(SAT_LO);
        return WIDTH'(x);
`else
        return WIDTH'(x);
`endif
    endfunction

    logic [0:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  ready_q;
    frame_t                fill_q, fill_d;
    frame_t                input_data_q, input_data_d;
    logic                  strobe_q, strobe_d;
    logic                  error_q, error_d;
    logic [15:0]           good_q, good_d;
    logic [7:0]            err_q, err_d;
    logic [LATENCY-1:0]    vld_q, vld_d;
    logic signed [WIDTH-1:0] sample_c;
    logic                  accept;

    assign sample_c = convert_sample(stream.s_data);
    assign accept   = stream.s_valid && ready_q;

    // Frame assembly, length policing and counter updates for the next cycle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        fill_d       = fill_q;
        input_data_d = input_data_q;
        strobe_d     = 1'b0;
        error_d      = 1'b0;
        good_d       = good_q;
        err_d        = err_q;
        // Valid token travels alongside the dense-layer pipeline.
        vld_d        = LATENCY'({vld_q, strobe_q});

        if (accept) begin
            case (state_q)
                ST_FILL: begin
                    if (stream.s_last && idx_q == IDX_LAST) begin
                        // Complete frame: last sample goes straight to the holding register.
                        input_data_d                 = fill_q;
                        input_data_d[INPUT_SIZE-1]   = sample_c;
                        strobe_d                     = 1'b1;
                        good_d                       = good_q + 16'd1;
                        idx_d                        = '0;
                    end else if (stream.s_last) begin
                        // Short frame: drop and restart cleanly on the next sample.
                        error_d = 1'b1;
                        idx_d   = '0;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end else if (idx_q == IDX_LAST) begin
                        // Long frame: drop, then swallow samples through its s_last.
                        error_d = 1'b1;
                        idx_d   = '0;
                        state_d = ST_DRAIN;
                        if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    end else begin
                        fill_d[idx_q] = sample_c;
                        idx_d         = idx_q + 1'b1;
                    end
                end
                default: begin
                    if (stream.s_last) begin
                        state_d = ST_FILL;
                        idx_d   = '0;
                    end
                end
            endcase
        end
    end

    // Control state, committed frame and counters; cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FILL;
            idx_q        <= '0;
            ready_q      <= 1'b0;
            input_data_q <= '0;
            strobe_q     <= 1'b0;
            error_q      <= 1'b0;
            good_q       <= '0;
            err_q        <= '0;
            vld_q        <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ready_q      <= 1'b1;
            input_data_q <= input_data_d;
            strobe_q     <= strobe_d;
            error_q      <= error_d;
            good_q       <= good_d;
            err_q        <= err_d;
            vld_q        <= vld_d;
        end
    end

    // Fill buffer is pure data; stale contents are never committed.
    always_ff @(posedge clk) begin
        fill_q <= fill_d;
    end

    assign stream.s_ready = ready_q;
    assign input_data     = input_data_q;
    assign frame_strobe   = strobe_q;
    assign result_valid   = vld_q[LATENCY-1];
    assign frame_error    = error_q;
    assign good_count     = good_q;
    assign err_count      = err_q;

endmodule

// File: doc/input_frame_loader.md
# input_frame_loader

Serial-to-parallel front end for the dense latency layer. It accepts one fixed-point sample per cycle over a valid/ready stream and assembles INPUT_SIZE samples into a frame. Each complete frame is committed in parallel onto the layer's input_data vector. A matching valid token is delayed by the layer's pipeline depth, so downstream logic knows when output_data belongs to a committed frame. It also polices frame length, drops malformed frames, and keeps good/bad frame counters.

## Interface
- WIDTH, 17: sample width presented to the dense layer (signed, fixed point).
- IN_WIDTH, 24: incoming sample width; IN_WIDTH >= WIDTH, same binary point (NFRAC unchanged).
- INPUT_SIZE, 32: samples per frame; >= 2.
- LATENCY, 8: cycles from an input_data update to the corresponding dense-layer output_data; >= 1.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- s_data  in  IN_WIDTH  signed incoming sample.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks final sample of a frame; qualified by s_valid.
- s_ready  out  1  loader accepts a sample this cycle.
- input_data  out  WIDTH x [0:INPUT_SIZE-1]  committed frame, drives the dense layer.
- frame_strobe  out  1  one-cycle pulse: input_data holds a newly committed frame.
- result_valid  out  1  dense-layer output_data corresponds to a committed frame.
- frame_error  out  1  one-cycle pulse: a frame was dropped.
- good_count  out  16  committed frames, wraps modulo 2^16.
- err_count  out  8  dropped frames, saturates at 255.

## Operation
- Accept: a sample transfers on a rising edge where s_valid && s_ready.
- s_ready is 0 while reset is low and for the first cycle after release. It is 1 at all other times; the dense layer is fully pipelined and never backpressures.
- Conversion: the sample is reduced from IN_WIDTH to WIDTH per the Configuration section.
- State FILL (reset state), index counter idx = 0..INPUT_SIZE-1:
  - Accepted sample with idx < INPUT_SIZE-1 and !s_last: write buf[idx], idx++.
  - Accepted sample with idx == INPUT_SIZE-1 and s_last: commit. input_data <= {buf[0..INPUT_SIZE-2], converted s_data}; frame_strobe pulses; good_count++; idx <= 0.
  - Accepted sample with s_last and idx < INPUT_SIZE-1 (short frame): drop; frame_error pulses; err_count++; idx <= 0; stay in FILL.
  - Accepted sample with idx == INPUT_SIZE-1 and !s_last (long frame): drop; frame_error pulses; err_count++; go to DRAIN.
- State DRAIN: discard accepted samples. On an accepted s_last, go to FILL with idx = 0. No second error is counted.
- buf is a single fill buffer. input_data is a separate holding register, so filling frame n+1 never disturbs frame n. input_data changes only on commit.
- Valid tracking: LATENCY-bit shift register fed by frame_strobe; result_valid = its last stage.
- Reset values: input_data all 0, frame_strobe 0, result_valid 0, frame_error 0, good_count 0, err_count 0, s_ready 0, idx 0, state FILL, shift register 0.

## Timing
- Commit: the last sample is accepted at edge T. input_data updates at T and frame_strobe is high for the cycle following T.
- result_valid goes high exactly LATENCY cycles after frame_strobe, for one cycle per committed frame.
- Back-to-back frames are permitted with zero gap; throughput is one sample per cycle.
- frame_strobe and result_valid may coincide; each is independent.
- frame_error is high for the cycle following the offending edge; it never coincides with frame_strobe for the same sample.
- Reset asserted mid-frame clears the partial frame and empties the valid shift register; no frame_error or result_valid is produced for in-flight data.
- Idle cycles (s_valid low) do not advance idx or state.

## Configuration
- LOADER_SAT_EN defined: samples outside the WIDTH range are clamped to the most positive (2^(WIDTH-1)-1) or most negative (-2^(WIDTH-1)) code.
- LOADER_SAT_EN undefined: conversion keeps s_data[WIDTH-1:0]; out-of-range values wrap.

## Test plan
- Nominal frame: 32 samples with values 1..32 and s_last on the 32nd. Required: input_data[k] = k+1; one frame_strobe; result_valid exactly 8 cycles later; good_count = 1.
- Back-to-back frames: three frames streamed with no idle cycles. Required: three frame_strobe pulses 32 cycles apart; three result_valid pulses; input_data stable between commits.
- Short frame: s_last on the 10th sample, then a good frame. Required: frame_error pulse; err_count = 1; no strobe for the short frame; the good frame commits normally.
- Long frame: 40 samples with s_last on the 40th. Required: one frame_error when sample 32 is accepted without s_last; samples 33–40 discarded; the next 32-sample frame commits.
- Saturation, with IN_WIDTH = 24 and WIDTH = 17:
  - s_data = 0x100000 gives 65535 when LOADER_SAT_EN is defined, 0 when it is undefined.
  - s_data = -70000 gives -65536 when LOADER_SAT_EN is defined.
- Reset mid-frame: assert reset after 20 samples. Required: all outputs go to zero immediately; s_ready stays low until one cycle after release; a following full frame commits with good_count = 1.
